// File: rtl/hawk_tol_list_ctrl.sv
// Tag-of-list controller: NUM_LISTS doubly linked lists threaded through a
// flop-based entry table. List 0 is the free list. One command runs at a time
// through a request/response port; MOVE takes an extra cycle for the re-push.
module hawk_tol_list_ctrl #(
   parameter int NUM_LISTS   = 4,
   parameter int NUM_ENTRIES = 16,
   parameter int ID_W        = $clog2(NUM_ENTRIES),
   parameter int LIST_W      = (NUM_LISTS > 1) ? $clog2(NUM_LISTS) : 1
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [1:0]                req_op,
   input  logic [LIST_W-1:0]         req_list,
   input  logic [LIST_W-1:0]         req_dst,
   input  logic [ID_W-1:0]           req_id,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [ID_W-1:0]           rsp_id,
   output logic                      rsp_err,
   output logic [NUM_LISTS*ID_W-1:0] list_head,
   output logic [NUM_LISTS*ID_W-1:0] list_tail,
   output logic [NUM_LISTS*ID_W-1:0] list_cnt,
   output logic [NUM_LISTS-1:0]      list_empty
);

   typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_PUSH2, ST_RESP} state_e;
   typedef enum logic [1:0] {OP_POP = 2'd0, OP_PUSH = 2'd1, OP_DETACH = 2'd2, OP_MOVE = 2'd3} op_e;

   // List indices are widened by one bit so the range check is meaningful
   // even when NUM_LISTS is not a power of two.
   localparam logic [LIST_W:0] NUM_LISTS_X = (LIST_W+1)'(NUM_LISTS);

   // FSM and registered command
   state_e            state_q, state_d;
   op_e               op_q, op_d;
   logic [LIST_W-1:0] list_q, list_d;
   logic [LIST_W-1:0] dst_q, dst_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
   logic              rsp_err_q, rsp_err_d;

   // Per-list state
   logic [ID_W-1:0]   head_q [NUM_LISTS];
   logic [ID_W-1:0]   head_d [NUM_LISTS];
   logic [ID_W-1:0]   tail_q [NUM_LISTS];
   logic [ID_W-1:0]   tail_d [NUM_LISTS];
   logic [ID_W-1:0]   cnt_q  [NUM_LISTS];
   logic [ID_W-1:0]   cnt_d  [NUM_LISTS];

   // Per-entry state
   logic [ID_W-1:0]   next_q  [NUM_ENTRIES];
   logic [ID_W-1:0]   next_d  [NUM_ENTRIES];
   logic [ID_W-1:0]   prev_q  [NUM_ENTRIES];
   logic [ID_W-1:0]   prev_d  [NUM_ENTRIES];
   logic [LIST_W-1:0] owner_q [NUM_ENTRIES];
   logic [LIST_W-1:0] owner_d [NUM_ENTRIES];
   logic              inl_q   [NUM_ENTRIES];
   logic              inl_d   [NUM_ENTRIES];

   // Decode helpers
   logic              list_ok, dst_ok, cmd_err;
   logic              do_pop, do_push, do_detach;
   logic [LIST_W-1:0] tgt;
   logic [ID_W-1:0]   pop_id, pop_nx, ent_nx, ent_pv, push_tail;

   // Next-state logic: command sequencing plus all list/table updates
   always_comb begin
      // NOTE: every variable gets its hold value first, so no path leaves one
      // unassigned and no latch is inferred.
      state_d   = state_q;
      op_d      = op_q;
      list_d    = list_q;
      dst_d     = dst_q;
      id_d      = id_q;
      rsp_id_d  = rsp_id_q;
      rsp_err_d = rsp_err_q;
      head_d    = head_q;
      tail_d    = tail_q;
      cnt_d     = cnt_q;
      next_d    = next_q;
      prev_d    = prev_q;
      owner_d   = owner_q;
      inl_d     = inl_q;
      do_pop    = 1'b0;
      do_push   = 1'b0;
      do_detach = 1'b0;
      tgt       = list_q;

      pop_id  = head_q[list_q];
      pop_nx  = next_q[pop_id];
      ent_nx  = next_q[id_q];
      ent_pv  = prev_q[id_q];
      list_ok = {1'b0, list_q} < NUM_LISTS_X;
      dst_ok  = {1'b0, dst_q} < NUM_LISTS_X;

      // Rejection rules; nothing is written when cmd_err is set
      unique case (op_q)
         OP_POP:  cmd_err = !list_ok || (cnt_q[list_q] == '0);
         OP_PUSH: cmd_err = !list_ok || (id_q == '0) || inl_q[id_q];
         default: cmd_err = !list_ok || (id_q == '0) || !inl_q[id_q] ||
                            (owner_q[id_q] != list_q) ||
                            ((op_q == OP_MOVE) && !dst_ok);
      endcase

      unique case (state_q)
         ST_IDLE: begin
            if (req_valid && req_ready) begin
               op_d    = op_e'(req_op);
               list_d  = req_list;
               dst_d   = req_dst;
               id_d    = req_id;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            rsp_err_d = cmd_err;
            rsp_id_d  = '0;
            state_d   = ST_RESP;
            if (!cmd_err) begin
               unique case (op_q)
                  OP_POP: begin
                     do_pop   = 1'b1;
                     rsp_id_d = pop_id;
                  end
                  OP_PUSH: begin
                     do_push  = 1'b1;
                     rsp_id_d = id_q;
                  end
                  OP_DETACH: begin
                     do_detach = 1'b1;
                     rsp_id_d  = id_q;
                  end
                  default: begin
                     // MOVE: unlink now, append to the destination next cycle
                     do_detach = 1'b1;
                     rsp_id_d  = id_q;
                     state_d   = ST_PUSH2;
                  end
               endcase
            end
         end
         ST_PUSH2: begin
            do_push = 1'b1;
            tgt     = dst_q;
            state_d = ST_RESP;
         end
         default: begin
            if (rsp_ready) begin
               rsp_id_d  = '0;
               rsp_err_d = 1'b0;
               state_d   = ST_IDLE;
            end
         end
      endcase

      push_tail = tail_q[tgt];

      // Pop the head; the new head loses its back pointer
      if (do_pop) begin
         head_d[list_q] = pop_nx;
         if (pop_nx != '0) prev_d[pop_nx] = '0;
         else              tail_d[list_q] = '0;
         next_d[pop_id] = '0;
         prev_d[pop_id] = '0;
         inl_d[pop_id]  = 1'b0;
         cnt_d[list_q]  = cnt_q[list_q] - ID_W'(1);
      end

      // Unlink an arbitrary entry; prev, next and id are distinct when non-zero
      if (do_detach) begin
         if (ent_pv != '0) next_d[ent_pv] = ent_nx;
         else              head_d[list_q] = ent_nx;
         if (ent_nx != '0) prev_d[ent_nx] = ent_pv;
         else              tail_d[list_q] = ent_pv;
         next_d[id_q]  = '0;
         prev_d[id_q]  = '0;
         inl_d[id_q]   = 1'b0;
         cnt_d[list_q] = cnt_q[list_q] - ID_W'(1);
      end

      // Append to the tail of the target list
      if (do_push) begin
         prev_d[id_q] = push_tail;
         next_d[id_q] = '0;
         if (push_tail != '0) next_d[push_tail] = id_q;
         else                 head_d[tgt]       = id_q;
         tail_d[tgt]   = id_q;
         owner_d[id_q] = tgt;
         inl_d[id_q]   = 1'b1;
         cnt_d[tgt]    = cnt_q[tgt] + ID_W'(1);
      end
   end

   // State registers; reset rebuilds the free list over entries 1..N-1
   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples its _d value from before this edge.
      if (rst_i) begin
         state_q   <= ST_IDLE;
         op_q      <= OP_POP;
         list_q    <= '0;
         dst_q     <= '0;
         id_q      <= '0;
         rsp_id_q  <= '0;
         rsp_err_q <= 1'b0;
         for (int k = 0; k < NUM_LISTS; k++) begin
            head_q[k] <= (k == 0) ? ID_W'(1) : '0;
            tail_q[k] <= (k == 0) ? ID_W'(NUM_ENTRIES-1) : '0;
            cnt_q[k]  <= (k == 0) ? ID_W'(NUM_ENTRIES-1) : '0;
         end
         // NOTE: the entry table must be reset because its reset contents
         // (the initial free chain) are architecturally visible.
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            next_q[i]  <= ((i == 0) || (i == NUM_ENTRIES-1)) ? '0 : ID_W'(i+1);
            prev_q[i]  <= (i < 2) ? '0 : ID_W'(i-1);
            owner_q[i] <= '0;
            inl_q[i]   <= (i != 0);
         end
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         list_q    <= list_d;
         dst_q     <= dst_d;
         id_q      <= id_d;
         rsp_id_q  <= rsp_id_d;
         rsp_err_q <= rsp_err_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         cnt_q     <= cnt_d;
         next_q    <= next_d;
         prev_q    <= prev_d;
         owner_q   <= owner_d;
         inl_q     <= inl_d;
      end
   end

   assign req_ready = (state_q == ST_IDLE) && !rst_i;
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_id    = rsp_id_q;
   assign rsp_err   = rsp_err_q;

   // Pack per-list registers onto the flat status buses
   always_comb begin
      list_head  = '0;
      list_tail  = '0;
      list_cnt   = '0;
      list_empty = '0;
      for (int k = 0; k < NUM_LISTS; k++) begin
         list_head[k*ID_W +: ID_W] = head_q[k];
         list_tail[k*ID_W +: ID_W] = tail_q[k];
         list_cnt[k*ID_W +: ID_W]  = cnt_q[k];
         list_empty[k]             = (cnt_q[k] == '0);
      end
   end

endmodule

// File: tb/tb_hawk_tol_list_ctrl.sv
// Directed bench for hawk_tol_list_ctrl with NUM_LISTS=4, NUM_ENTRIES=8.
// A table of commands with hand-computed responses and list snapshots is
// replayed in order, followed by hand-written reset corner sequences.
module tb_hawk_tol_list_ctrl;

   localparam int NL = 4;
   localparam int NE = 8;
   localparam int IW = 3;
   localparam int LW = 2;

   localparam logic [1:0] OP_POP    = 2'd0;
   localparam logic [1:0] OP_PUSH   = 2'd1;
   localparam logic [1:0] OP_DETACH = 2'd2;
   localparam logic [1:0] OP_MOVE   = 2'd3;

   typedef struct {
      logic [1:0]      op;
      logic [LW-1:0]   lst;
      logic [LW-1:0]   dst;
      logic [IW-1:0]   id;
      logic            err;
      logic [IW-1:0]   rid;
      int              hold;
      logic [NL*IW-1:0] head;
      logic [NL*IW-1:0] tail;
      logic [NL*IW-1:0] cnt;
      logic [NL-1:0]   empty;
   } vec_t;

   logic              clk_i = 1'b0;
   logic              rst_i = 1'b1;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic [1:0]        req_op = '0;
   logic [LW-1:0]     req_list = '0;
   logic [LW-1:0]     req_dst = '0;
   logic [IW-1:0]     req_id = '0;
   logic              rsp_valid;
   logic              rsp_ready = 1'b0;
   logic [IW-1:0]     rsp_id;
   logic              rsp_err;
   logic [NL*IW-1:0]  list_head, list_tail, list_cnt;
   logic [NL-1:0]     list_empty;

   int n_checks = 0;
   int n_errors = 0;

   vec_t vecs[24];
   vec_t last_vec;

   hawk_tol_list_ctrl #(.NUM_LISTS(NL), .NUM_ENTRIES(NE)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_list   (req_list),
      .req_dst    (req_dst),
      .req_id     (req_id),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_err    (rsp_err),
      .list_head  (list_head),
      .list_tail  (list_tail),
      .list_cnt   (list_cnt),
      .list_empty (list_empty)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Pack four per-list values, list 0 in the low bits
   function automatic logic [NL*IW-1:0] pk(input int a0, input int a1, input int a2, input int a3);
      return {IW'(a3), IW'(a2), IW'(a1), IW'(a0)};
   endfunction

   function automatic vec_t mk(input logic [1:0] op, input int l, input int d, input int id,
                               input int err, input int rid, input int hold,
                               input logic [NL*IW-1:0] h, input logic [NL*IW-1:0] t,
                               input logic [NL*IW-1:0] c, input logic [NL-1:0] e);
      vec_t v;
      v.op = op; v.lst = LW'(l); v.dst = LW'(d); v.id = IW'(id);
      v.err = (err != 0); v.rid = IW'(rid); v.hold = hold;
      v.head = h; v.tail = t; v.cnt = c; v.empty = e;
      return v;
   endfunction

   task automatic check_lists(input string tag, input logic [NL*IW-1:0] h, input logic [NL*IW-1:0] t,
                              input logic [NL*IW-1:0] c, input logic [NL-1:0] e);
      check({tag, " list_head"},  32'(list_head),  32'(h));
      check({tag, " list_tail"},  32'(list_tail),  32'(t));
      check({tag, " list_cnt"},   32'(list_cnt),   32'(c));
      check({tag, " list_empty"}, 32'(list_empty), 32'(e));
   endtask

   // Bounded wait for req_ready at a falling edge
   task automatic wait_ready(input string tag);
      int n;
      n = 0;
      @(negedge clk_i);
      while (!req_ready && n < 20) begin
         @(negedge clk_i);
         n++;
      end
      check({tag, " req_ready"}, 32'(req_ready), 32'd1);
      check({tag, " idle rsp_valid"}, 32'(rsp_valid), 32'd0);
   endtask

   task automatic issue(input logic [1:0] op, input logic [LW-1:0] l, input logic [LW-1:0] d,
                        input logic [IW-1:0] id);
      req_valid = 1'b1;
      req_op    = op;
      req_list  = l;
      req_dst   = d;
      req_id    = id;
      @(posedge clk_i);
      #1 req_valid = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int lat;
      int exp_lat;
      wait_ready(tag);
      issue(v.op, v.lst, v.dst, v.id);
      exp_lat = ((v.op == OP_MOVE) && !v.err) ? 3 : 2;
      lat = 0;
      do begin
         @(negedge clk_i);
         lat++;
      end while (!rsp_valid && lat < 20);
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check({tag, " rsp_err"}, 32'(rsp_err), 32'(v.err));
      check({tag, " rsp_id"},  32'(rsp_id),  32'(v.rid));
      check_lists(tag, v.head, v.tail, v.cnt, v.empty);
      for (int h = 0; h < v.hold; h++) begin
         @(negedge clk_i);
         check({tag, " hold rsp_valid"}, 32'(rsp_valid), 32'd1);
         check({tag, " hold rsp_id"},    32'(rsp_id),    32'(v.rid));
         check({tag, " hold req_ready"}, 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk_i);
      #1 rsp_ready = 1'b0;
   endtask

   initial begin
      // Command table: op, list, dst, id, err, rsp_id, hold, head, tail, cnt, empty
      vecs[0]  = mk(OP_POP,    0, 0, 0, 0, 1, 5, pk(2,0,0,0), pk(7,0,0,0), pk(6,0,0,0), 4'b1110);
      vecs[1]  = mk(OP_PUSH,   2, 0, 1, 0, 1, 0, pk(2,0,1,0), pk(7,0,1,0), pk(6,0,1,0), 4'b1010);
      vecs[2]  = mk(OP_DETACH, 0, 0, 4, 0, 4, 0, pk(2,0,1,0), pk(7,0,1,0), pk(5,0,1,0), 4'b1010);
      vecs[3]  = mk(OP_POP,    0, 0, 0, 0, 2, 0, pk(3,0,1,0), pk(7,0,1,0), pk(4,0,1,0), 4'b1010);
      vecs[4]  = mk(OP_POP,    0, 0, 0, 0, 3, 0, pk(5,0,1,0), pk(7,0,1,0), pk(3,0,1,0), 4'b1010);
      vecs[5]  = mk(OP_POP,    0, 0, 0, 0, 5, 0, pk(6,0,1,0), pk(7,0,1,0), pk(2,0,1,0), 4'b1010);
      vecs[6]  = mk(OP_POP,    0, 0, 0, 0, 6, 0, pk(7,0,1,0), pk(7,0,1,0), pk(1,0,1,0), 4'b1010);
      vecs[7]  = mk(OP_POP,    0, 0, 0, 0, 7, 0, pk(0,0,1,0), pk(0,0,1,0), pk(0,0,1,0), 4'b1011);
      vecs[8]  = mk(OP_POP,    0, 0, 0, 1, 0, 0, pk(0,0,1,0), pk(0,0,1,0), pk(0,0,1,0), 4'b1011);
      vecs[9]  = mk(OP_PUSH,   0, 0, 2, 0, 2, 0, pk(2,0,1,0), pk(2,0,1,0), pk(1,0,1,0), 4'b1010);
      vecs[10] = mk(OP_PUSH,   0, 0, 7, 0, 7, 0, pk(2,0,1,0), pk(7,0,1,0), pk(2,0,1,0), 4'b1010);
      vecs[11] = mk(OP_PUSH,   0, 0, 6, 0, 6, 0, pk(2,0,1,0), pk(6,0,1,0), pk(3,0,1,0), 4'b1010);
      vecs[12] = mk(OP_MOVE,   0, 3, 7, 0, 7, 0, pk(2,0,1,7), pk(6,0,1,7), pk(2,0,1,1), 4'b0010);
      vecs[13] = mk(OP_PUSH,   3, 0, 2, 1, 0, 0, pk(2,0,1,7), pk(6,0,1,7), pk(2,0,1,1), 4'b0010);
      vecs[14] = mk(OP_DETACH, 1, 0, 2, 1, 0, 0, pk(2,0,1,7), pk(6,0,1,7), pk(2,0,1,1), 4'b0010);
      vecs[15] = mk(OP_DETACH, 3, 0, 7, 0, 7, 0, pk(2,0,1,0), pk(6,0,1,0), pk(2,0,1,0), 4'b1010);
      vecs[16] = mk(OP_PUSH,   0, 0, 5, 0, 5, 0, pk(2,0,1,0), pk(5,0,1,0), pk(3,0,1,0), 4'b1010);
      vecs[17] = mk(OP_MOVE,   0, 0, 6, 0, 6, 0, pk(2,0,1,0), pk(6,0,1,0), pk(3,0,1,0), 4'b1010);
      vecs[18] = mk(OP_POP,    0, 0, 0, 0, 2, 0, pk(5,0,1,0), pk(6,0,1,0), pk(2,0,1,0), 4'b1010);
      vecs[19] = mk(OP_POP,    0, 0, 0, 0, 5, 0, pk(6,0,1,0), pk(6,0,1,0), pk(1,0,1,0), 4'b1010);
      vecs[20] = mk(OP_DETACH, 0, 0, 6, 0, 6, 0, pk(0,0,1,0), pk(0,0,1,0), pk(0,0,1,0), 4'b1011);
      vecs[21] = mk(OP_PUSH,   1, 0, 0, 1, 0, 0, pk(0,0,1,0), pk(0,0,1,0), pk(0,0,1,0), 4'b1011);
      vecs[22] = mk(OP_MOVE,   2, 1, 1, 0, 1, 0, pk(0,1,0,0), pk(0,1,0,0), pk(0,1,0,0), 4'b1101);
      vecs[23] = mk(OP_DETACH, 0, 0, 1, 1, 0, 0, pk(0,1,0,0), pk(0,1,0,0), pk(0,1,0,0), 4'b1101);

      // Reset state
      rst_i = 1'b1;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      check("reset req_ready", 32'(req_ready), 32'd0);
      check("reset rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset rsp_id",    32'(rsp_id),    32'd0);
      check("reset rsp_err",   32'(rsp_err),   32'd0);
      check_lists("reset", pk(1,0,0,0), pk(7,0,0,0), pk(7,0,0,0), 4'b1110);
      rst_i = 1'b0;
      @(posedge clk_i);
      @(negedge clk_i);
      check("post-reset req_ready", 32'(req_ready), 32'd1);

      // Table replay
      for (int i = 0; i < 24; i++) begin
         run_vec(vecs[i], $sformatf("v%0d", i));
      end

      // Reset during PUSH2 of MOVE(1 -> 2, id 1)
      wait_ready("rstmove");
      issue(OP_MOVE, LW'(1), LW'(2), IW'(1));
      @(negedge clk_i);                       // EXEC
      check("rstmove exec rsp_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk_i);                       // PUSH2, detached state visible
      check("rstmove push2 rsp_valid", 32'(rsp_valid), 32'd0);
      check("rstmove push2 list_cnt", 32'(list_cnt), 32'(pk(0,0,0,0)));
      check("rstmove push2 list_empty", 32'(list_empty), 32'(4'b1111));
      rst_i = 1'b1;
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      @(negedge clk_i);
      check_lists("rstmove after", pk(1,0,0,0), pk(7,0,0,0), pk(7,0,0,0), 4'b1110);
      for (int k = 0; k < 3; k++) begin
         check("rstmove no rsp_valid", 32'(rsp_valid), 32'd0);
         @(negedge clk_i);
      end

      // Controller is usable again from the rebuilt free list
      last_vec = mk(OP_POP, 0, 0, 0, 0, 1, 0, pk(2,0,0,0), pk(7,0,0,0), pk(6,0,0,0), 4'b1110);
      run_vec(last_vec, "post-rst pop");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
